// File: rtl/clmul_acc_8bit.sv
// Carry-less 8x8 multiply (low byte only) with XOR accumulation over FRAME_LEN
// operand pairs; one result per frame delivered over a valid/ready handshake.
module clmul_acc_8bit #(
    parameter int FRAME_LEN = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic [7:0] frame_cnt
);

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);

    // Low byte of the carry-less product: bit k collects every a[i]&b[k-i].
    function automatic logic [7:0] clmul8_lo(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i <= k; i++) begin
                p[k] = p[k] ^ (a[i] & b[k - i]);
            end
        end
        return p;
    endfunction

    state_t     r_state;
    state_t     w_state_next;

    logic [4:0] r_cnt;
    logic       r_s1_valid;
    logic [7:0] r_s1_a;
    logic [7:0] r_s1_b;
    logic       r_s1_first;
    logic       r_s1_last;
    logic [7:0] r_acc;

    logic       r_in_ready;
    logic       r_out_valid;
    logic [7:0] r_out_data;
    logic [7:0] r_frame_cnt;

    logic       w_accept;
    logic       w_handshake;
    logic       w_first;
    logic       w_last;
    logic [7:0] w_prod;
    logic       w_in_ready_next;
    logic       w_out_valid_next;
    logic       w_load_out;

    assign w_accept    = in_valid & r_in_ready;
    assign w_handshake = r_out_valid & out_ready;
    assign w_first     = (r_cnt == 5'd0);
    assign w_last      = (r_cnt == LAST_IDX);
    assign w_prod      = clmul8_lo(r_s1_a, r_s1_b);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; DRAIN waits until the last pair has left stage 1
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_ACC: begin
                if (w_accept && w_last) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_state_next = ST_ACC;
                end
            end
            ST_DRAIN: begin
                if (r_s1_valid && r_s1_last) begin
                    w_state_next = ST_DRAIN;
                end else begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_handshake) begin
                    w_state_next = ST_ACC;
                end else begin
                    w_state_next = ST_HOLD;
                end
            end
            default: begin
                w_state_next = ST_ACC;
            end
        endcase
    end

    // Output decode: next values of the registered handshake outputs
    always_comb begin
        w_in_ready_next  = 1'b0;
        w_out_valid_next = 1'b0;
        w_load_out       = 1'b0;
        case (w_state_next)
            ST_ACC: begin
                w_in_ready_next = 1'b1;
            end
            ST_HOLD: begin
                w_out_valid_next = 1'b1;
                if (r_state == ST_DRAIN) begin
                    w_load_out = 1'b1;
                end else begin
                    w_load_out = 1'b0;
                end
            end
            default: begin
                w_in_ready_next  = 1'b0;
                w_out_valid_next = 1'b0;
            end
        endcase
    end

    // Registered outputs; in_ready stays low for the reset cycle itself
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
        end else begin
            r_in_ready  <= w_in_ready_next;
            r_out_valid <= w_out_valid_next;
            if (w_load_out) begin
                r_out_data <= r_acc;
            end else begin
                r_out_data <= r_out_data;
            end
        end
    end

    // Position of the next accepted pair within the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 5'd0;
        end else if (w_accept) begin
            if (w_last) begin
                r_cnt <= 5'd0;
            end else begin
                r_cnt <= r_cnt + 5'd1;
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Stage 1: operand capture with frame-position flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= 8'h00;
            r_s1_b     <= 8'h00;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_a     <= in_a;
                r_s1_b     <= in_b;
                r_s1_first <= w_first;
                r_s1_last  <= w_last;
            end else begin
                r_s1_a     <= r_s1_a;
                r_s1_b     <= r_s1_b;
                r_s1_first <= r_s1_first;
                r_s1_last  <= r_s1_last;
            end
        end
    end

    // Stage 2: first product of a frame overwrites, later ones XOR in
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= 8'h00;
        end else if (r_s1_valid) begin
            if (r_s1_first) begin
                r_acc <= w_prod;
            end else begin
                r_acc <= r_acc ^ w_prod;
            end
        end else begin
            r_acc <= r_acc;
        end
    end

    // Delivered-result counter, wraps naturally at 8 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= 8'h00;
        end else if (w_handshake) begin
            r_frame_cnt <= r_frame_cnt + 8'd1;
        end else begin
            r_frame_cnt <= r_frame_cnt;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_clmul_acc_8bit.sv
// Self-checking bench for clmul_acc_8bit: directed frame table, reset/backpressure
// sequences, random frames against a shift-and-XOR reference, and counter wrap.
module tb_clmul_acc_8bit;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_frames = 0;

    clmul_acc_8bit #(.FRAME_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Pair bytes are packed with pair 0 in bits [7:0].
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  exp;
        int          hold;
    } vec_t;

    function automatic logic [7:0] ref_clmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] full;
        full = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) full = full ^ ({8'h00, a} << i);
        end
        return full[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'h00);
        check("rst_frame_cnt", {24'd0, frame_cnt}, 32'h00);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        exp_frames = 0;
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic drive_pair(input logic [7:0] a, input logic [7:0] b, input bit gappy);
        int budget;
        if (gappy) begin
            while ($urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
                in_a = 8'($urandom);
                in_b = 8'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        budget = 0;
        while (!in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) check("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_a = 8'($urandom);
        in_b = 8'($urandom);
    endtask

    // Called right after the last accept; checks latency, stability under hold, handshake.
    task automatic get_result(input logic [7:0] exp, input int hold, input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 10) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, 32'd2);
        check({tag, "_data"}, {24'd0, out_data}, {24'd0, exp});
        if (hold > 0) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
                check({tag, "_hold_data"}, {24'd0, out_data}, {24'd0, exp});
                check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        exp_frames++;
        check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_in_ready_back"}, {31'd0, in_ready}, 32'd1);
        check({tag, "_frame_cnt"}, {24'd0, frame_cnt}, 32'(exp_frames % 256));
    endtask

    vec_t vecs[8];

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] rexp;

        vecs[0] = '{a: {8'h80, 8'hFF, 8'h02, 8'h03}, b: {8'h02, 8'h01, 8'h02, 8'h03}, exp: 8'hFE, hold: 0};
        vecs[1] = '{a: {8'h00, 8'h00, 8'h00, 8'h03}, b: {8'h00, 8'h00, 8'h00, 8'h03}, exp: 8'h05, hold: 0};
        vecs[2] = '{a: {8'h00, 8'h00, 8'h00, 8'h80}, b: {8'h00, 8'h00, 8'h00, 8'h02}, exp: 8'h00, hold: 0};
        vecs[3] = '{a: {8'h00, 8'h00, 8'h00, 8'hFF}, b: {8'h00, 8'h00, 8'h00, 8'hFF}, exp: 8'h55, hold: 0};
        vecs[4] = '{a: {8'h00, 8'h00, 8'h00, 8'h0F}, b: {8'h00, 8'h00, 8'h00, 8'h11}, exp: 8'hFF, hold: 0};
        vecs[5] = '{a: {8'h00, 8'h03, 8'hFF, 8'h0F}, b: {8'h00, 8'h03, 8'hFF, 8'h11}, exp: 8'hAF, hold: 10};
        vecs[6] = '{a: {8'h02, 8'h03, 8'h03, 8'h00}, b: {8'h02, 8'h03, 8'h03, 8'h00}, exp: 8'h04, hold: 2};
        vecs[7] = '{a: {8'h00, 8'h00, 8'h00, 8'h01}, b: {8'h00, 8'h00, 8'h00, 8'hAB}, exp: 8'hAB, hold: 0};

        rst = 1'b1;
        in_valid = 1'b0;
        in_a = 8'h00;
        in_b = 8'h00;
        out_ready = 1'b0;
        do_reset();

        for (int v = 0; v < 8; v++) begin
            for (int p = 0; p < 4; p++) begin
                drive_pair(vecs[v].a[8*p +: 8], vecs[v].b[8*p +: 8], 1'b0);
            end
            get_result(vecs[v].exp, vecs[v].hold, $sformatf("vec%0d", v));
        end

        // Abort a half-sent frame with reset; the following frame must start clean.
        drive_pair(8'h03, 8'h03, 1'b0);
        drive_pair(8'h02, 8'h02, 1'b0);
        do_reset();
        for (int p = 0; p < 4; p++) drive_pair(8'h01, 8'h01, 1'b0);
        get_result(8'h00, 0, "abort");

        // Random frames with input gaps against the reference model.
        do_reset();
        for (int f = 0; f < 20; f++) begin
            rexp = 8'h00;
            for (int p = 0; p < 4; p++) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                rexp = rexp ^ ref_clmul(ra, rb);
                drive_pair(ra, rb, 1'b1);
            end
            get_result(rexp, $urandom_range(0, 3), $sformatf("rnd%0d", f));
        end
        check("rnd_frame_cnt_20", {24'd0, frame_cnt}, 32'd20);

        // 257 frames from reset wrap the result counter to 1.
        do_reset();
        for (int f = 0; f < 257; f++) begin
            ra = 8'(f);
            rexp = ref_clmul(ra, 8'h01) ^ ref_clmul(8'h01, 8'h01);
            drive_pair(ra, 8'h01, 1'b0);
            drive_pair(8'h01, 8'h01, 1'b0);
            drive_pair(8'h00, 8'h5A, 1'b0);
            drive_pair(8'h00, 8'h00, 1'b0);
            get_result(rexp, 0, "wrap");
        end
        check("wrap_frame_cnt", {24'd0, frame_cnt}, 32'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clmul_acc_8bit.md
CLMUL_ACC_8BIT -- requirements
Module: clmul_acc_8bit

Interface
REQ-001 Parameter FRAME_LEN, default 4, meaning samples per accumulation frame; legal range 2..16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 in_valid  input  1  in_a/in_b carry a valid operand pair.
REQ-005 in_ready  output  1  block accepts a pair this cycle.
REQ-006 in_a  input  8  multiplicand.
REQ-007 in_b  input  8  multiplier.
REQ-008 out_valid  output  1  out_data holds a completed frame result.
REQ-009 out_ready  input  1  downstream accepts the result this cycle.
REQ-010 out_data  output  8  XOR-accumulated truncated carry-less product of one frame.
REQ-011 frame_cnt  output  8  number of results delivered since reset, modulo 256.

Function
REQ-012 Product definition: p[k] = XOR over all i+j=k (0<=i,j<=7) of in_a[i] AND in_b[j], for k=0..7 only; terms with i+j>7 are discarded; no carries anywhere.
REQ-013 Accept event: in_valid=1 and in_ready=1 on a rising edge; no other condition consumes a pair.
REQ-014 Stage 1: on accept, register in_a, in_b, a first-of-frame flag and a last-of-frame flag.
REQ-015 Stage 2: one cycle after accept, acc <= p if first flag set, else acc ^ p.
REQ-016 Input counter counts accepts 0..FRAME_LEN-1, wraps to 0 after the FRAME_LEN-th accept; the accept at count 0 is first, at FRAME_LEN-1 is last.
REQ-017 States: ACC (in_ready=1, collecting), DRAIN (last pair in stage 1, in_ready=0), HOLD (out_valid=1, in_ready=0).
REQ-018 ACC -> DRAIN on the last-of-frame accept; DRAIN -> HOLD next cycle, loading out_data with the final acc value; HOLD -> ACC on out_valid=1 and out_ready=1.
REQ-019 Latency: last pair accepted at edge t -> out_valid=1 and out_data valid after edge t+2.
REQ-020 out_data and out_valid stay stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-021 On result handshake at edge t: out_valid=0 and in_ready=1 after edge t; frame_cnt increments by 1 at edge t, wrapping 255 -> 0.
REQ-022 out_ready is ignored while out_valid=0; in_a/in_b are ignored while in_ready=0 or in_valid=0.
REQ-023 in_valid gaps mid-frame are allowed: acc and counters hold; no timeout.
REQ-024 Back-to-back throughput: one accept per cycle within a frame; minimum 3-cycle gap between last accept of one frame and first accept of the next with out_ready held 1.
REQ-025 No combinational path from in_valid to in_ready or from out_ready to out_valid; in_ready and out_valid are register outputs.

Reset
REQ-026 While rst=1 at an edge: state=ACC, input counter=0, stage-1 valid=0, acc=0x00, out_data=0x00, out_valid=0, frame_cnt=0x00.
REQ-027 in_ready=0 during the cycle rst is asserted and 1 from the first edge with rst=0.
REQ-028 Reset mid-frame or in HOLD discards all partial and pending results; the next accepted pair is first-of-frame.

Verification
REQ-029 FRAME_LEN=4, pairs (03,03),(02,02),(FF,01),(80,02) on consecutive cycles, out_ready=1 -> out_valid one cycle, out_data=0xFE two edges after 4th accept, frame_cnt=1.
REQ-030 Single-product check per pair: (03,03)->0x05, (80,02)->0x00, (FF,FF)->0x55, (0F,11)->0xFF, verified as frames with remaining pairs (00,00).
REQ-031 Backpressure: out_ready=0 for 10 cycles after result -> out_valid and out_data stable, in_ready=0 throughout, no pair accepted; release -> in_ready=1 next cycle.
REQ-032 Random in_valid gaps (50%) over 20 frames compared against a software model of REQ-012 -> all 20 results match, frame_cnt=20.
REQ-033 Assert rst after 2 of 4 pairs, then send full frame (01,01)x4 -> out_data=0x00, no result from the aborted frame.
REQ-034 Deliver 257 frames -> frame_cnt wraps to 0x01.
